// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
// Build option: define REGFILE_WR_BYPASS_EN for write-through read forwarding.
package regfile_pkg;

    // CLEAR encodes as zero so a zero-initialised power-up starts clearing
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_GP   = 28;
    localparam int unsigned REG_SP   = 29;

    localparam logic [31:0] GP_INIT_DEF = 32'h1000_8000;
    localparam logic [31:0] SP_INIT_DEF = 32'd16464;

    // Value the clear engine writes into a given register index
    function automatic logic [63:0] init_value(
        input int unsigned idx,
        input int unsigned gp_idx,
        input int unsigned sp_idx,
        input logic [63:0] gp_init,
        input logic [63:0] sp_init
    );
        logic [63:0] v;
        v = '0;
        if (idx == gp_idx) begin
            v = gp_init;
        end else if (idx == sp_idx) begin
            v = sp_init;
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequential clear engine: walks every register index once after reset.
// Busy stays high until the last index has been written.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              Busy,
    output logic              ClrWe,
    output logic [ADDR_W-1:0] ClrIdx
);

    rf_state_e state;

    // Restart on reset, otherwise step through the array once
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= CLEAR;
            ClrIdx <= '0;
        end else if (state == CLEAR) begin
            ClrIdx <= ClrIdx + 1'b1;
            if (ClrIdx == {ADDR_W{1'b1}}) begin
                state <= READY;
            end
        end
    end

    assign Busy  = (state == CLEAR);
    assign ClrWe = (state == CLEAR) && !Rst;

endmodule

// File: rtl/param_register_file.sv
// ID-stage register file: NUM_RD async read ports, one write port, clear engine.
// Build option: define REGFILE_WR_BYPASS_EN for same-cycle write forwarding.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int          NUM_RD   = 2,
    parameter int          GP_IDX   = REG_GP,
    parameter logic [63:0] GP_INIT  = 64'(GP_INIT_DEF),
    parameter int          SP_IDX   = REG_SP,
    parameter logic [63:0] SP_INIT  = 64'(SP_INIT_DEF),
    parameter int          TAP0_IDX = 9,
    parameter int          TAP1_IDX = 11
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    input  logic [ADDR_W-1:0]        WriteRegister,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     RegWrite,
    output logic                     Busy,
    output logic [DATA_W-1:0]        Tap0,
    output logic [DATA_W-1:0]        Tap1
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] T0 = ADDR_W'(TAP0_IDX);
    localparam logic [ADDR_W-1:0] T1 = ADDR_W'(TAP1_IDX);

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_rd
        $error("NUM_RD must be 1..4");
    end
    if (GP_IDX <= 0 || GP_IDX >= DEPTH) begin : g_bad_gp
        $error("GP_IDX out of range");
    end
    if (SP_IDX <= 0 || SP_IDX >= DEPTH) begin : g_bad_sp
        $error("SP_IDX out of range");
    end
    if (TAP0_IDX < 0 || TAP0_IDX >= DEPTH) begin : g_bad_t0
        $error("TAP0_IDX out of range");
    end
    if (TAP1_IDX < 0 || TAP1_IDX >= DEPTH) begin : g_bad_t1
        $error("TAP1_IDX out of range");
    end

    logic [DATA_W-1:0] regs [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] clr_val;
    logic              byp_en;
    logic              wr_en;

    regfile_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .Clk    (Clk),
        .Rst    (Rst),
        .Busy   (busy),
        .ClrWe  (clr_we),
        .ClrIdx (clr_idx)
    );

    assign Busy    = busy;
    assign clr_val = DATA_W'(init_value(32'(clr_idx), GP_IDX, SP_IDX,
                                        GP_INIT, SP_INIT));

    // A normal write that would land this edge; reset also blocks it
    assign byp_en = !busy && RegWrite && (WriteRegister != '0);
    assign wr_en  = byp_en && !Rst;

    // Clear engine owns the write port while busy
    always_ff @(posedge Clk) begin
        if (clr_we) begin
            regs[clr_idx] <= clr_val;
        end else if (wr_en) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] val;

        assign idx = ReadRegister[k*ADDR_W +: ADDR_W];

        // Async read; r0 and busy force zero
        always_comb begin
            val = regs[idx];
`ifdef REGFILE_WR_BYPASS_EN
            if (byp_en && (WriteRegister == idx)) begin
                val = WriteData;
            end
`endif
            if (busy || (idx == '0)) begin
                val = '0;
            end
        end

        assign ReadData[k*DATA_W +: DATA_W] = val;
    end

    // Debug taps stay live during clear
    always_comb begin
        Tap0 = regs[T0];
        Tap1 = regs[T1];
`ifdef REGFILE_WR_BYPASS_EN
        if (byp_en && (WriteRegister == T0)) begin
            Tap0 = WriteData;
        end
        if (byp_en && (WriteRegister == T1)) begin
            Tap1 = WriteData;
        end
`endif
    end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file (NUM_RD=3, DATA_W=32).
// Reference model predicts each cycle; a monitor compares at negedge.
module tb_param_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int DEPTH = 32;

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [NR*AW-1:0] ReadRegister = '0;
    logic [NR*DW-1:0] ReadData;
    logic [AW-1:0]    WriteRegister = '0;
    logic [DW-1:0]    WriteData = '0;
    logic             RegWrite = 1'b0;
    logic             Busy;
    logic [DW-1:0]    Tap0;
    logic [DW-1:0]    Tap1;

    always #5 Clk = ~Clk;

    param_register_file #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .ReadRegister  (ReadRegister),
        .ReadData      (ReadData),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .Busy          (Busy),
        .Tap0          (Tap0),
        .Tap1          (Tap1)
    );

    typedef struct {
        logic             busy;
        logic [NR*DW-1:0] rd;
        logic [DW-1:0]    t0;
        logic [DW-1:0]    t1;
        bit               k0;
        bit               k1;
    } exp_t;

    exp_t sbq[$];

    int n_pass = 0;
    int n_total = 0;

    // Reference model: array contents plus clear progress
    logic [DW-1:0] m_reg [DEPTH];
    bit            m_known [DEPTH];
    bit            m_busy = 1'b1;
    int            m_pos = 0;

    function automatic logic [DW-1:0] init_of(input int i);
        if (i == 28) return 32'h1000_8000;
        if (i == 29) return 32'd16464;
        return '0;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: drive inputs, push the prediction, advance the model
    task automatic cyc(input bit rst, input bit we, input int wr,
                       input logic [DW-1:0] wd,
                       input int r0, input int r1, input int r2);
        exp_t e;
        int   ri [NR];
        bit   fwd;
        @(posedge Clk);
        #1;
        ri = '{r0, r1, r2};
        Rst = rst;
        RegWrite = we;
        WriteRegister = wr[AW-1:0];
        WriteData = wd;
        for (int k = 0; k < NR; k++) begin
            ReadRegister[k*AW +: AW] = ri[k][AW-1:0];
        end
        fwd = BYP && !m_busy && we && (wr != 0);
        e.busy = m_busy;
        for (int k = 0; k < NR; k++) begin
            if (m_busy || ri[k] == 0) e.rd[k*DW +: DW] = '0;
            else if (fwd && wr == ri[k]) e.rd[k*DW +: DW] = wd;
            else e.rd[k*DW +: DW] = m_reg[ri[k]];
        end
        e.t0 = (fwd && wr == 9) ? wd : m_reg[9];
        e.t1 = (fwd && wr == 11) ? wd : m_reg[11];
        e.k0 = m_known[9] || (fwd && wr == 9);
        e.k1 = m_known[11] || (fwd && wr == 11);
        sbq.push_back(e);
        if (rst) begin
            m_busy = 1'b1;
            m_pos = 0;
        end else if (m_busy) begin
            m_reg[m_pos] = init_of(m_pos);
            m_known[m_pos] = 1'b1;
            m_pos++;
            if (m_pos == DEPTH) m_busy = 1'b0;
        end else if (we && wr != 0) begin
            m_reg[wr] = wd;
        end
    endtask

    task automatic idle(input int r0, input int r1, input int r2);
        cyc(1'b0, 1'b0, 0, '0, r0, r1, r2);
    endtask

    function automatic int ri32();
        return int'($urandom_range(0, 31));
    endfunction

    task automatic rnd(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), ri32(), $urandom,
                ri32(), ri32(), ri32());
        end
    endtask

    // Monitor: compare DUT outputs against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("busy", DW'(Busy), DW'(e.busy));
                for (int k = 0; k < NR; k++) begin
                    chk($sformatf("rd%0d", k), ReadData[k*DW +: DW],
                        e.rd[k*DW +: DW]);
                end
                if (e.k0) chk("tap0", Tap0, e.t0);
                if (e.k1) chk("tap1", Tap1, e.t1);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i] = '0;
            m_known[i] = 1'b0;
        end
        // reset, then writes during clear must be ignored
        cyc(1'b1, 1'b0, 0, '0, 0, 0, 0);
        cyc(1'b0, 1'b1, 5, 32'h55, 5, 28, 29);
        for (int i = 0; i < 34; i++) begin
            cyc(1'b0, 1'b1, ri32(), $urandom, ri32(), 28, 29);
        end
        idle(5, 28, 29);
        // taps and ports
        cyc(1'b0, 1'b1, 9, 32'hDEAD_BEEF, 9, 11, 0);
        cyc(1'b0, 1'b1, 11, 32'd7, 9, 11, 11);
        idle(9, 11, 9);
        // register zero
        cyc(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        idle(0, 0, 0);
        // same-cycle read of a written register
        cyc(1'b0, 1'b1, 3, 32'h1234, 3, 3, 3);
        idle(3, 3, 3);
        rnd(300);
        // restart clear mid-way
        cyc(1'b0, 1'b1, 20, 32'hAB, 20, 9, 11);
        idle(20, 20, 20);
        cyc(1'b1, 1'b0, 0, '0, 20, 0, 0);
        for (int i = 0; i < 10; i++) idle(20, 28, 29);
        cyc(1'b1, 1'b0, 0, '0, 20, 28, 29);
        for (int i = 0; i < 34; i++) idle(20, 28, 29);
        idle(20, 9, 11);
        rnd(100);
        idle(1, 2, 31);
        for (int i = 0; i < 4 && sbq.size() != 0; i++) @(negedge Clk);
        @(negedge Clk);
        chk("drain", DW'(sbq.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
